// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - transfer and response encodings shared by the bus responder
package bus_responder_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      NONSEQ = 1'b1
   } pkg_trans;

   typedef enum logic [1:0] {
      PENDING = 2'd0,
      SUCCESS = 2'd1,
      ERROR_1 = 2'd2,
      ERROR_2 = 2'd3
   } pkg_resp;

endpackage

// File: rtl/bus_responder_decode.sv
// rtl/bus_responder_decode.sv - combinational request decoder; read-only window under BUS_RESPONDER_RO_EN
module bus_responder_decode
   import bus_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   parameter int RO_WORDS   = 4
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   output logic [1:0]            resp
);

   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   logic [ADDR_WIDTH-1:0] word;
   logic                  misaligned;
   logic                  out_of_range;
   logic                  ro_hit;

   // full-width compare so high address bits never alias into storage
   assign word         = addr >> BYTE_SHIFT;
   assign misaligned   = |addr[BYTE_SHIFT-1:0];
   assign out_of_range = (word >= ADDR_WIDTH'(DEPTH));

`ifdef BUS_RESPONDER_RO_EN
   assign ro_hit = write && (word < ADDR_WIDTH'(RO_WORDS));
`else
   logic unused_ro;
   assign unused_ro = write ^ (RO_WORDS != 0);
   assign ro_hit    = 1'b0;
`endif

   always_comb begin
      resp = SUCCESS;
      if (misaligned)
         resp = ERROR_2;
      else if (out_of_range)
         resp = ERROR_1;
      else if (ro_hit)
         resp = ERROR_2;
   end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - memory-backed bus responder with fixed wait states; option BUS_RESPONDER_RO_EN
module bus_responder
   import bus_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int RO_WORDS    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_trans,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic                  i_write,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [1:0]            o_resp,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                state, state_next;
   logic                  accept;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic                  lat_write;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] dec_addr;
   logic                  dec_write;
   logic [DATA_WIDTH-1:0] dec_wdata;
   logic [1:0]            dec_resp;
   logic [IDX_W-1:0]      idx;

   // with zero wait states the response is formed on the accepting edge, so decode the live inputs
   assign dec_addr  = (state == S_IDLE) ? i_addr  : lat_addr;
   assign dec_write = (state == S_IDLE) ? i_write : lat_write;
   assign dec_wdata = (state == S_IDLE) ? i_wdata : lat_wdata;
   assign idx       = dec_addr[BYTE_SHIFT +: IDX_W];

   bus_responder_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .RO_WORDS   (RO_WORDS)
   ) u_decode (
      .addr  (dec_addr),
      .write (dec_write),
      .resp  (dec_resp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_trans == NONSEQ) begin
               accept     = 1'b1;
               state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == CNT_W'(1))
               state_next = S_RESP;
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
         o_resp    <= PENDING;
         o_rdata   <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (accept) begin
            lat_addr  <= i_addr;
            lat_write <= i_write;
            lat_wdata <= i_wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
         end else if (state == S_WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (state_next == S_RESP) begin
            o_resp  <= dec_resp;
            o_rdata <= (dec_resp == SUCCESS && !dec_write) ? mem[idx] : '0;
            if (dec_resp == SUCCESS && dec_write)
               mem[idx] <= dec_wdata;
         end else begin
            o_resp  <= PENDING;
            o_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed bench for bus_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_bus_responder;
   import bus_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        trans0 = 1'b0, write0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [1:0]  resp0;
   logic [31:0] rdata0;

   logic        trans1 = 1'b0, write1 = 1'b0;
   logic [31:0] addr1 = '0, wdata1 = '0;
   logic [1:0]  resp1;
   logic [31:0] rdata1;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bus_responder #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .i_trans(trans0), .i_addr(addr0), .i_write(write0),
      .i_wdata(wdata0), .o_resp(resp0), .o_rdata(rdata0)
   );

   bus_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .i_trans(trans1), .i_addr(addr1), .i_write(write1),
      .i_wdata(wdata1), .o_resp(resp1), .o_rdata(rdata1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int sel, input logic t, input logic [31:0] a,
                          input logic w, input logic [31:0] d);
      if (sel == 0) begin
         trans0 = t; addr0 = a; write0 = w; wdata0 = d;
      end else begin
         trans1 = t; addr1 = a; write1 = w; wdata1 = d;
      end
   endtask

   function automatic logic [1:0] cur_resp(input int sel);
      return (sel == 0) ? resp0 : resp1;
   endfunction

   function automatic logic [31:0] cur_rdata(input int sel);
      return (sel == 0) ? rdata0 : rdata1;
   endfunction

   // counts negedges until a non-PENDING response, bounded
   task automatic wait_resp(input int sel, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (cur_resp(sel) == PENDING && lat < 12);
   endtask

   task automatic xfer(input int sel, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [1:0] exp_resp, input logic [31:0] exp_rdata, input string tag);
      int lat;
      set_req(sel, 1'b1, a, w, d);
      wait_resp(sel, lat);
      check({tag, "_lat"}, lat, (sel == 0) ? 3 : 1);
      check({tag, "_resp"}, cur_resp(sel), exp_resp);
      check({tag, "_rdata"}, cur_rdata(sel), exp_rdata);
      set_req(sel, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
   endtask

   task automatic b2b(input int sel, input logic w, input logic [31:0] base, input logic [31:0] seed);
      int lat;
      int per;
      per = (sel == 0) ? 4 : 2;
      for (int i = 0; i < 4; i++) begin
         set_req(sel, 1'b1, base + 32'(4 * i), w, seed + 32'(i));
         wait_resp(sel, lat);
         check($sformatf("b2b%0d_w%0d_lat%0d", sel, w, i), lat, (i == 0) ? per - 1 : per);
         check($sformatf("b2b%0d_w%0d_resp%0d", sel, w, i), cur_resp(sel), SUCCESS);
         check($sformatf("b2b%0d_w%0d_rdata%0d", sel, w, i), cur_rdata(sel),
               w ? 32'h0 : seed + 32'(i));
      end
      set_req(sel, 1'b0, '0, 1'b0, '0);
      repeat (per - 1) @(negedge clk);
      check($sformatf("b2b%0d_w%0d_nodup", sel, w), cur_resp(sel), PENDING);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_resp", resp0, PENDING);
      check("rst_rdata", rdata0, 32'h0);
      check("rst_resp_w0", resp1, PENDING);
      rst = 1'b0;
      @(negedge clk);

      xfer(0, 32'h40, 1'b1, 32'hDEADBEEF, SUCCESS, 32'h0, "t1_wr");
      xfer(0, 32'h40, 1'b0, 32'h0, SUCCESS, 32'hDEADBEEF, "t1_rd");

      xfer(0, 32'h100, 1'b0, 32'h0, ERROR_1, 32'h0, "t2_rd_oor");
      xfer(0, 32'hFFFF_FFFC, 1'b1, 32'h1111_1111, ERROR_1, 32'h0, "t2_wr_oor");
      xfer(0, 32'hFC, 1'b0, 32'h0, SUCCESS, 32'h0, "t2_noalias");

      xfer(0, 32'h42, 1'b1, 32'h1234, ERROR_2, 32'h0, "t3_wr_mis");
      xfer(0, 32'h40, 1'b0, 32'h0, SUCCESS, 32'hDEADBEEF, "t3_rd_keep");
      xfer(0, 32'h101, 1'b0, 32'h0, ERROR_2, 32'h0, "t3_mis_oor");

`ifdef BUS_RESPONDER_RO_EN
      xfer(0, 32'h04, 1'b1, 32'hA5A5A5A5, ERROR_2, 32'h0, "t4_wr_ro");
      xfer(0, 32'h04, 1'b0, 32'h0, SUCCESS, 32'h0, "t4_rd_ro");
`else
      xfer(0, 32'h04, 1'b1, 32'hA5A5A5A5, SUCCESS, 32'h0, "t4_wr");
      xfer(0, 32'h04, 1'b0, 32'h0, SUCCESS, 32'hA5A5A5A5, "t4_rd");
`endif

      set_req(0, 1'b1, 32'h08, 1'b1, 32'h55);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_rst_resp", resp0, PENDING);
      check("t5_rst_rdata", rdata0, 32'h0);
      set_req(0, 1'b0, '0, 1'b0, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xfer(0, 32'h08, 1'b0, 32'h0, SUCCESS, 32'h0, "t5_rd_discard");
      xfer(0, 32'h40, 1'b0, 32'h0, SUCCESS, 32'h0, "t5_rd_cleared");

      b2b(0, 1'b1, 32'h20, 32'h1000_0000);
      b2b(0, 1'b0, 32'h20, 32'h1000_0000);
      b2b(1, 1'b1, 32'h30, 32'h2000_0000);
      b2b(1, 1'b0, 32'h30, 32'h2000_0000);

      xfer(1, 32'h100, 1'b0, 32'h0, ERROR_1, 32'h0, "t6_w0_oor");
      xfer(1, 32'h32, 1'b1, 32'h77, ERROR_2, 32'h0, "t6_w0_mis");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
